// File: rtl/m92_pkg.sv
// Shared M92 video definitions: palette entry layout, bank IO address and
// the 5-to-8 bit colour expansion.
package m92_pkg;

   localparam int unsigned PAL_DW      = 16;
   localparam logic [7:0]  PAL_BANK_IO = 8'h02;

   typedef struct packed {
      logic       x;
      logic [4:0] b;
      logic [4:0] g;
      logic [4:0] r;
   } pal_entry_t;

   // Replicate the top bits so 5'h1F maps to full-scale 8'hFF
   function automatic logic [7:0] pal5to8(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

endpackage

// File: rtl/m92_palette_ram.sv
// True dual-port palette RAM: port A is the CPU (byte writes, registered read),
// port B is the video read with a pixel-enable gated address and data register.
module m92_palette_ram
   import m92_pkg::*;
#(
   parameter int unsigned AW = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     addr_a,
   input  logic [PAL_DW-1:0] din_a,
   input  logic [1:0]        be_a,
   input  logic              we_a,
   input  logic              re_a,
   output logic [PAL_DW-1:0] q_a,
   input  logic              ce_b,
   input  logic [AW-1:0]     addr_b,
   output logic [PAL_DW-1:0] q_b
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [PAL_DW-1:0] mem [DEPTH];
   logic [AW-1:0]     addr_b_q;

   // Contents are never reset
   always_ff @(posedge clk) begin
      if (we_a) begin
         if (be_a[0]) mem[addr_a][7:0]  <= din_a[7:0];
         if (be_a[1]) mem[addr_a][15:8] <= din_a[15:8];
      end
   end

   // Video read sees the pre-write word when both ports hit the same entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_a      <= '0;
         addr_b_q <= '0;
         q_b      <= '0;
      end else begin
         if (re_a) q_a <= mem[addr_a];
         if (ce_b) begin
            addr_b_q <= addr_b;
            q_b      <= mem[addr_b_q];
         end
      end
   end

endmodule

// File: rtl/m92_palette_mixer.sv
// M92 final video stage: sprite/background priority, palette lookup and
// 8-bit RGB output with blanking carried through the 3-stage pixel pipeline.
module m92_palette_mixer
   import m92_pkg::*;
#(
   parameter int unsigned PAL_AW      = 11,
   parameter bit          BLANK_BLACK = 1'b1
) (
   input  logic        CLK_32M,
   input  logic        RESET_N,
   input  logic        CE_PIX,
   input  logic [19:0] A,
   input  logic [15:0] DIN,
   input  logic [1:0]  BYTE_SEL,
   input  logic        MRD,
   input  logic        MWR,
   input  logic        palette_memrq,
   output logic [15:0] DOUT,
   input  logic [7:0]  IO_A,
   input  logic [7:0]  IO_DIN,
   input  logic        IOWR,
   input  logic [10:0] bg_color,
   input  logic        bg_prio,
   input  logic [10:0] obj_color,
   input  logic        obj_prio,
   input  logic        HBLANK,
   input  logic        VBLANK,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic        HBLANK_OUT,
   output logic        VBLANK_OUT,
   input  logic        en_obj,
   input  logic        en_bg
);

   logic              bank;
   logic              obj_opaque;
   logic              bg_opaque;
   logic [10:0]       sel;
   logic [PAL_AW-1:0] vid_addr;
   logic [PAL_AW-1:0] cpu_addr;
   logic [15:0]       vid_q;
   pal_entry_t        pix;
   logic              hb_s1, vb_s1, hb_s2, vb_s2;
   logic              unused_bits;

   always_ff @(posedge CLK_32M) begin
      if (!RESET_N)                          bank <= 1'b0;
      else if (IOWR && IO_A == PAL_BANK_IO)  bank <= IO_DIN[1];
   end

   assign obj_opaque = en_obj && (obj_color[3:0] != 4'd0);
   assign bg_opaque  = en_bg  && (bg_color[3:0]  != 4'd0);

   // Layer priority; falls back to the background index (pen 0 if all clear)
   always_comb begin
      sel = bg_color;
      if (obj_opaque && obj_prio)      sel = obj_color;
      else if (bg_opaque && bg_prio)   sel = bg_color;
      else if (obj_opaque)             sel = obj_color;
   end

   assign vid_addr = {bank, sel[PAL_AW-2:0]};
   assign cpu_addr = {bank, A[PAL_AW-1:1]};

   m92_palette_ram #(.AW(PAL_AW)) u_ram (
      .clk    (CLK_32M),
      .rst_n  (RESET_N),
      .addr_a (cpu_addr),
      .din_a  (DIN),
      .be_a   (BYTE_SEL),
      .we_a   (palette_memrq & MWR),
      .re_a   (palette_memrq & MRD),
      .q_a    (DOUT),
      .ce_b   (CE_PIX),
      .addr_b (vid_addr),
      .q_b    (vid_q)
   );

   assign pix = pal_entry_t'(vid_q);

   // Blank delay line and RGB expansion; blanks reset high so the flushed
   // pipeline shows black until the first real pixel reaches the output
   always_ff @(posedge CLK_32M) begin
      if (!RESET_N) begin
         hb_s1      <= 1'b1;
         vb_s1      <= 1'b1;
         hb_s2      <= 1'b1;
         vb_s2      <= 1'b1;
         HBLANK_OUT <= 1'b1;
         VBLANK_OUT <= 1'b1;
         R          <= 8'd0;
         G          <= 8'd0;
         B          <= 8'd0;
      end else if (CE_PIX) begin
         hb_s1      <= HBLANK;
         vb_s1      <= VBLANK;
         hb_s2      <= hb_s1;
         vb_s2      <= vb_s1;
         HBLANK_OUT <= hb_s2;
         VBLANK_OUT <= vb_s2;
         if (BLANK_BLACK && (hb_s2 || vb_s2)) begin
            R <= 8'd0;
            G <= 8'd0;
            B <= 8'd0;
         end else begin
            R <= pal5to8(pix.r);
            G <= pal5to8(pix.g);
            B <= pal5to8(pix.b);
         end
      end
   end

   assign unused_bits = ^{A[19:PAL_AW], A[0], IO_DIN[7:2], IO_DIN[0], sel[10], pix.x};

endmodule

// File: tb/tb_m92_palette_mixer.sv
// Scoreboard bench for m92_palette_mixer: a behavioural palette/priority model
// predicts each pixel; a monitor compares on every pixel-enable edge.
module tb_m92_palette_mixer;

   logic        CLK_32M = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CE_PIX = 1'b0;
   logic [19:0] A = '0;
   logic [15:0] DIN = '0;
   logic [1:0]  BYTE_SEL = '0;
   logic        MRD = 1'b0, MWR = 1'b0, palette_memrq = 1'b0;
   logic [15:0] DOUT;
   logic [7:0]  IO_A = '0, IO_DIN = '0;
   logic        IOWR = 1'b0;
   logic [10:0] bg_color = '0, obj_color = '0;
   logic        bg_prio = 1'b0, obj_prio = 1'b0;
   logic        HBLANK = 1'b0, VBLANK = 1'b0;
   logic [7:0]  R, G, B;
   logic        HBLANK_OUT, VBLANK_OUT;
   logic        en_obj = 1'b1, en_bg = 1'b1;

   typedef struct {
      logic [7:0] r, g, b;
      logic       hb, vb;
   } exp_t;

   exp_t        sb[$];
   exp_t        last_exp;
   exp_t        rst_e;
   logic [15:0] mem_m [2048];
   logic        bank_m = 1'b0;
   int          checks = 0;
   int          passed = 0;

   m92_palette_mixer #(.PAL_AW(11), .BLANK_BLACK(1'b1)) dut (
      .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .A(A), .DIN(DIN),
      .BYTE_SEL(BYTE_SEL), .MRD(MRD), .MWR(MWR), .palette_memrq(palette_memrq),
      .DOUT(DOUT), .IO_A(IO_A), .IO_DIN(IO_DIN), .IOWR(IOWR),
      .bg_color(bg_color), .bg_prio(bg_prio), .obj_color(obj_color), .obj_prio(obj_prio),
      .HBLANK(HBLANK), .VBLANK(VBLANK), .R(R), .G(G), .B(B),
      .HBLANK_OUT(HBLANK_OUT), .VBLANK_OUT(VBLANK_OUT), .en_obj(en_obj), .en_bg(en_bg)
   );

   always #5 CLK_32M = ~CLK_32M;

   // ---------------- reference model ----------------
   function automatic logic [7:0] expand(input logic [4:0] c);
      logic [7:0] w;
      w = {3'b000, c};
      return (w << 3) | (w >> 2);
   endfunction

   function automatic logic [23:0] rgb_of(input logic [15:0] w);
      return {expand(w[4:0]), expand(w[9:5]), expand(w[14:10])};
   endfunction

   function automatic exp_t model_pix(input logic [10:0] bc, input logic bp,
                                      input logic [10:0] oc, input logic op,
                                      input logic eb, input logic eo,
                                      input logic hb, input logic vb);
      logic        obj_vis, bg_vis;
      logic [10:0] idx;
      logic [23:0] rgb;
      exp_t        e;
      obj_vis = eo && (oc[3:0] != 4'd0);
      bg_vis  = eb && (bc[3:0] != 4'd0);
      if (obj_vis && op)      idx = oc;
      else if (bg_vis && bp)  idx = bc;
      else if (obj_vis)       idx = oc;
      else                    idx = bc;
      rgb = (hb || vb) ? 24'd0 : rgb_of(mem_m[{bank_m, idx[9:0]}]);
      e.r = rgb[23:16]; e.g = rgb[15:8]; e.b = rgb[7:0];
      e.hb = hb; e.vb = vb;
      return e;
   endfunction

   // ---------------- comparisons ----------------
   function automatic void check_px(input string name, input exp_t e);
      checks++;
      if (R === e.r && G === e.g && B === e.b && HBLANK_OUT === e.hb && VBLANK_OUT === e.vb)
         passed++;
      else
         $display("FAIL %s @%0t: got R=%h G=%h B=%h HB=%b VB=%b, want R=%h G=%h B=%h HB=%b VB=%b",
                  name, $time, R, G, B, HBLANK_OUT, VBLANK_OUT, e.r, e.g, e.b, e.hb, e.vb);
   endfunction

   function automatic void check16(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h, want %h", name, got, want);
   endfunction

   function automatic void check24(input string name, input logic [23:0] got, input logic [23:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got RGB=%h, want %h", name, got, want);
   endfunction

   function automatic void check_int(input string name, input int got, input int want);
      checks++;
      if (got == want) passed++;
      else $display("FAIL %s: got %0d, want %0d", name, got, want);
   endfunction

   // Monitor: pop on every pixel-enable edge, otherwise outputs must hold
   always @(posedge CLK_32M) begin
      if (RESET_N) begin
         if (CE_PIX) begin
            #1;
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL sb_underflow @%0t: got an output with no expected entry, want one", $time);
            end else begin
               last_exp = sb.pop_front();
               check_px("pixel", last_exp);
            end
         end else begin
            #1;
            check_px("hold", last_exp);
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [10:0] rnd_col();
      logic [10:0] c;
      c = 11'($urandom);
      if ($urandom_range(0, 2) == 0) c[3:0] = 4'd0;
      return c;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK_32M);
         CE_PIX = 1'b0;
      end
   endtask

   task automatic pix(input logic [10:0] bc, input logic bp, input logic [10:0] oc, input logic op,
                      input logic eb, input logic eo, input logic hb, input logic vb, input int gap);
      @(negedge CLK_32M);
      bg_color = bc; bg_prio = bp; obj_color = oc; obj_prio = op;
      en_bg = eb; en_obj = eo; HBLANK = hb; VBLANK = vb; CE_PIX = 1'b1;
      sb.push_back(model_pix(bc, bp, oc, op, eb, eo, hb, vb));
      for (int i = 0; i < gap; i++) begin
         @(negedge CLK_32M);
         CE_PIX = 1'b0;
         bg_color = 11'($urandom); obj_color = 11'($urandom);
         bg_prio = 1'($urandom); obj_prio = 1'($urandom);
         HBLANK = 1'($urandom); VBLANK = 1'($urandom);
      end
   endtask

   // Push two pixels that read entry {bank,0}, which is never rewritten later,
   // so in-flight reads cannot be disturbed by subsequent CPU writes
   task automatic flush();
      pix(11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'($urandom), 1'($urandom), 0);
      pix(11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'($urandom), 1'($urandom), 0);
   endtask

   task automatic directed(input string name, input logic [10:0] bc, input logic bp,
                           input logic [10:0] oc, input logic op, input logic eb, input logic eo,
                           input logic [23:0] want);
      pix(bc, bp, oc, op, eb, eo, 1'b0, 1'b0, 0);
      flush();
      idle(1);
      check24(name, {R, G, B}, want);
   endtask

   task automatic rand_stream(input int n, input int maxgap);
      for (int i = 0; i < n; i++)
         pix(rnd_col(), 1'($urandom), rnd_col(), 1'($urandom),
             ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             int'($urandom_range(0, maxgap)));
      flush();
   endtask

   task automatic cpu_write(input logic [9:0] word, input logic [15:0] d, input logic [1:0] be,
                            input logic sel);
      @(negedge CLK_32M);
      CE_PIX = 1'b0;
      A = {9'($urandom), word, 1'($urandom)};
      DIN = d; BYTE_SEL = be; palette_memrq = sel; MWR = 1'b1;
      @(negedge CLK_32M);
      palette_memrq = 1'b0; MWR = 1'b0;
      if (sel) begin
         if (be[0]) mem_m[{bank_m, word}][7:0]  = d[7:0];
         if (be[1]) mem_m[{bank_m, word}][15:8] = d[15:8];
      end
   endtask

   task automatic cpu_read(input string name, input logic [9:0] word);
      logic [15:0] want;
      @(negedge CLK_32M);
      CE_PIX = 1'b0;
      A = {9'($urandom), word, 1'($urandom)};
      palette_memrq = 1'b1; MRD = 1'b1;
      @(negedge CLK_32M);
      palette_memrq = 1'b0; MRD = 1'b0; A = 20'($urandom);
      want = mem_m[{bank_m, word}];
      check16(name, DOUT, want);
      @(negedge CLK_32M);
      check16({name, "_hold"}, DOUT, want);
   endtask

   task automatic io_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge CLK_32M);
      CE_PIX = 1'b0;
      IO_A = a; IO_DIN = d; IOWR = 1'b1;
      @(negedge CLK_32M);
      IOWR = 1'b0;
      if (a == 8'h02) bank_m = d[1];
   endtask

   task automatic do_reset();
      @(negedge CLK_32M);
      RESET_N = 1'b0; CE_PIX = 1'b0;
      @(negedge CLK_32M);
      check_px("reset_out", rst_e);
      sb.delete();
      sb.push_back(rst_e);
      sb.push_back(rst_e);
      last_exp = rst_e;
      bank_m = 1'b0;
      RESET_N = 1'b1;
   endtask

   initial begin
      rst_e.r = 8'd0; rst_e.g = 8'd0; rst_e.b = 8'd0; rst_e.hb = 1'b1; rst_e.vb = 1'b1;
      last_exp = rst_e;
      do_reset();

      // Fill both banks with known data
      for (int bk = 0; bk < 2; bk++) begin
         io_write(8'h02, {6'($urandom), 1'(bk), 1'($urandom)});
         for (int w = 0; w < 1024; w++) cpu_write(10'(w), 16'($urandom), 2'b11, 1'b1);
      end
      io_write(8'h02, 8'h00);

      // Basic write / lookup / readback
      cpu_write(10'h012, 16'h7C1F, 2'b11, 1'b1);
      directed("plan_012", 11'h012, 1'b0, 11'h120, 1'b0, 1'b1, 1'b1, 24'hFF00FF);
      cpu_read("cpu_rd_012", 10'h012);

      // Priority and transparency
      cpu_write(10'h021, 16'h001F, 2'b11, 1'b1);
      cpu_write(10'h105, 16'h7C00, 2'b11, 1'b1);
      cpu_write(10'h230, 16'h03E0, 2'b11, 1'b1);
      cpu_write(10'h031, 16'h4210, 2'b11, 1'b1);
      directed("prio_bg",        11'h021, 1'b1, 11'h105, 1'b0, 1'b1, 1'b1, 24'hFF0000);
      directed("prio_obj_force", 11'h021, 1'b1, 11'h105, 1'b1, 1'b1, 1'b1, 24'h0000FF);
      directed("prio_obj_plain", 11'h021, 1'b0, 11'h105, 1'b0, 1'b1, 1'b1, 24'h0000FF);
      directed("transp_both",    11'h230, 1'b0, 11'h100, 1'b1, 1'b1, 1'b1, 24'h00FF00);
      directed("en_obj_off",     11'h031, 1'b0, 11'h105, 1'b1, 1'b1, 1'b0, 24'h848484);
      directed("en_bg_off",      11'h031, 1'b1, 11'h105, 1'b0, 1'b0, 1'b1, 24'h0000FF);
      directed("sel10_ignored",  11'h412, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 24'hFF00FF);

      // Byte lanes and unselected writes
      cpu_write(10'h055, 16'hABCD, 2'b01, 1'b1);
      cpu_read("byte_lo", 10'h055);
      cpu_write(10'h055, 16'h1234, 2'b10, 1'b1);
      cpu_read("byte_hi", 10'h055);
      cpu_write(10'h056, 16'h5A5A, 2'b11, 1'b0);
      cpu_read("no_memrq", 10'h056);

      // Bank register: wrong IO address ignored, then bank 1
      io_write(8'h03, 8'h02);
      directed("io_wrong_addr", 11'h012, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 24'hFF00FF);
      io_write(8'h02, 8'h02);
      cpu_write(10'h010, 16'h03E0, 2'b11, 1'b1);
      directed("bank1_lookup", 11'h010, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 24'h00FF00);
      cpu_read("bank1_rd_010", 10'h010);
      io_write(8'h02, 8'h00);
      cpu_read("bank0_010_kept", 10'h010);

      // Single blanked pixel with enable every third clock
      for (int i = 0; i < 6; i++)
         pix(rnd_col(), 1'($urandom), rnd_col(), 1'($urandom), 1'b1, 1'b1, (i == 2), 1'b0, 2);
      flush();

      // Randomised traffic with interleaved CPU and bank updates
      for (int ph = 0; ph < 6; ph++) begin
         io_write(8'h02, 8'($urandom));
         repeat (8) cpu_write(10'($urandom_range(1, 1023)), 16'($urandom), 2'($urandom), 1'b1);
         rand_stream(40, (ph % 2 == 0) ? 0 : 3);
      end

      // Reset mid-line with bank 1 active
      io_write(8'h02, 8'h02);
      for (int i = 0; i < 5; i++)
         pix(rnd_col(), 1'($urandom), rnd_col(), 1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 2);
      do_reset();
      directed("bank_after_reset", 11'h010, 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, rgb_of(mem_m[11'h010]));
      cpu_read("ram_survives_reset", 10'h012);
      check16("ram_012_value", mem_m[11'h012], 16'h7C1F);
      rand_stream(30, 2);

      idle(3);
      check_int("sb_depth_end", sb.size(), 2);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/m92_palette_mixer.md
# m92_palette_mixer

Final video stage on the M92 board. Merges the background pixel from the B-D layer board with the sprite pixel, resolves priority, and looks the winning colour up in a CPU-writable palette RAM. Produces 8-bit RGB with blanking aligned to the pixel pipeline. Sits between the background/sprite outputs and the video scaler.

## Interface
Parameters:
- PAL_AW, 11, palette RAM address width (2048 entries × 16 bit)
- BLANK_BLACK, 1, force RGB to 0 while blanked

Ports:
- CLK_32M  in  1  system clock
- RESET_N  in  1  synchronous, active-low reset
- CE_PIX  in  1  pixel clock enable; all pipeline stages advance only on it
- A  in  20  CPU address; palette window is A[10:1] (1024 words)
- DIN  in  16  CPU write data
- BYTE_SEL  in  2  CPU byte lanes
- MRD, MWR  in  1  CPU memory read / write strobes
- palette_memrq  in  1  palette window decode
- DOUT  out  16  CPU read data
- IO_A  in  8  CPU IO address
- IO_DIN  in  8  CPU IO data
- IOWR  in  1  IO write strobe
- bg_color  in  11  background colour index (palette[10:4], pen[3:0])
- bg_prio  in  1  background high-priority flag
- obj_color  in  11  sprite colour index
- obj_prio  in  1  sprite force-front flag
- HBLANK, VBLANK  in  1  raw blanking, aligned with the pixel inputs
- R, G, B  out  8 each  output colour
- HBLANK_OUT, VBLANK_OUT  out  1  blanking delayed to match RGB
- en_obj, en_bg  in  1  debug layer enables (0 = treat the layer as transparent)

## Operation
- Transparency: a layer is transparent when its pen [3:0] == 0, or when its enable is 0.
- Selection, in priority order:
  - sprite opaque and obj_prio=1 → sprite
  - bg opaque and bg_prio=1 → bg
  - sprite opaque → sprite
  - otherwise → bg (includes the all-transparent case: bg index with pen 0)
- Palette address = {bank, sel[10:0]} truncated to PAL_AW. Bank is 1 bit, so only sel[9:0] is used when PAL_AW=11.
- Bank register:
  - Written by IOWR with IO_A == 8'h02; takes IO_DIN[1].
  - Reset value 0.
  - The CPU window also uses the bank: CPU address = {bank, A[10:1]}.
- Palette entry format is xBBBBBGGGGGRRRRR. Each 5-bit channel c expands to 8 bits as {c, c[4:2]}.
- CPU port:
  - Dual-port RAM with byte writes; write occurs when palette_memrq & MWR.
  - DOUT is registered, valid the cycle after the address; it is held when not selected.
- Simultaneous CPU write and video read of the same entry: the video port returns the old data.
- Reset:
  - Clears bank, all pipeline registers, R/G/B = 0, HBLANK_OUT = VBLANK_OUT = 1.
  - RAM contents are not cleared.
  - Reset mid-frame flushes the pipeline; the first valid pixel appears 3 CE_PIX after release.

## Timing
- Pipeline has 3 stages, each advancing on CE_PIX:
  - S1: register the selected index and the blanks.
  - S2: palette RAM read (registered q).
  - S3: expand to 8-bit and register RGB.
- Latency: exactly 3 CE_PIX pulses from input to R/G/B. HBLANK_OUT and VBLANK_OUT carry the same 3-stage delay.
- With BLANK_BLACK=1, S3 outputs 0 when either delayed blank is set.
- With CE_PIX low, all outputs hold their values.
- The CPU port is independent of CE_PIX and has 1-cycle read latency.
- A bank write takes effect on the next clock: it affects the next S1 capture and the next CPU access.

## Structure
- Shared package m92_pkg holds:
  - palette entry typedef (5/5/5 fields)
  - IO address constant PAL_BANK_IO = 8'h02
  - expansion function pal5to8
- Sub-module m92_palette_ram: true dual-port 2^PAL_AW × 16 RAM.
  - Port A: CPU, byte enables, read/write.
  - Port B: video, read only, CE-gated address register.
- Priority selection and the pipeline stay in the top module.

## Test plan
- Write entry 0x012 = 16'h7C1F via CPU (bank 0); drive bg_color=11'h012, bg_prio=0, obj pen 0; pulse CE_PIX 3 times → R=8'hFF, G=8'h00, B=8'hFF; CPU read of the same address returns 16'h7C1F.
- Priority: bg_color=11'h021 (bg_prio=1), obj_color=11'h105 (obj_prio=0) → index 0x021 is looked up. Set obj_prio=1 → index 0x105 is looked up. Set bg_prio=0, obj_prio=0 → 0x105.
- Transparency: bg pen 0 and obj pen 0, bg_color=11'h230 → index 0x230 is looked up. Set en_obj=0 with obj_color=11'h105, bg_color=11'h031 → 0x031.
- Bank: IOWR IO_A=8'h02, IO_DIN=8'h02; CPU writes word 0x010 = 16'h03E0; bg index 0x010 → RAM address 0x410 is read, G=8'hFF, R=B=0. Bank 0 entry 0x010 is unchanged.
- Blanking/CE: assert HBLANK for one pixel with CE_PIX every 3rd clock → HBLANK_OUT and RGB=0 exactly 3 CE_PIX later; outputs are stable between enables.
- Reset: assert RESET_N=0 mid-line → next clock RGB=0, blanks=1, bank=0. After release, 3 CE_PIX pass before valid colour; RAM contents survive.
